nios_systemqsys_onchip_mem_arbiter: RTL and testbench
=====================================================

# nios_systemqsys_onchip_mem_arbiter

Two-master round-robin arbiter sharing the single-port 38400×32 on-chip RAM between the Nios II data master and a DMA/accelerator master. Sits between the two Avalon-MM masters and the RAM's s1 port: serialises commands onto the one physical port, returns read data to the right master after the RAM's fixed 1-cycle latency, and keeps per-master grant statistics.

## Interface
- DEPTH, 38400: valid words; addresses >= DEPTH are out-of-range (OOR).
- OOR_DATA, 32'hDEAD_BEEF: read data returned for OOR reads.
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- mN_address  in  16  word address, N = 0,1 (same for all mN_* ports).
- mN_byteenable  in  4  byte lanes for writes.
- mN_read / mN_write  in  1  command strobes.
- mN_writedata  in  32  write data.
- mN_waitrequest  out  1  1 = command not accepted this cycle.
- mN_readdata  out  32  read data.
- mN_readdatavalid  out  1  1-cycle pulse qualifying mN_readdata.
- mem_address  out  16; mem_byteenable  out  4; mem_writedata  out  32.
- mem_chipselect / mem_write  out  1  RAM command.
- mem_clken  out  1  = ~reset.
- mem_readdata  in  32  RAM q, valid the cycle after a read is issued.
- grant_cnt0 / grant_cnt1  out  32  accepted commands per master, wrap at 2^32.
- err_flags  out  2  sticky: [0] OOR access, [1] read and write asserted together.

## Operation
- Request: reqN = mN_read | mN_write. At most one grant per cycle; grant is combinational from reqN and registered pointer last_gnt.
- Arbitration: only one requester -> it wins. Both -> master != last_gnt wins. last_gnt updates to the winner on every grant; resets to 1 (so m0 wins first tie).
- Granted master: mN_waitrequest = 0; loser and any requester while reset = 1 see waitrequest = 1. Non-requesting master's waitrequest = 1 (don't care to masters, fixed for checking).
- Command mux: winner's address/byteenable/writedata to mem_*; mem_chipselect = grant & in-range; mem_write = grant & write.
- Read+write together: write executes, read dropped (no readdatavalid), err_flags[1] set.
- OOR (address >= DEPTH): mem_chipselect = 0; write discarded; read still answered with OOR_DATA; err_flags[0] set. Counted in grant_cnt.
- Return pipeline: register rd_vld, rd_owner, rd_oor on an accepted read. Next cycle: mN_readdatavalid = rd_vld & (rd_owner == N); mN_readdata = rd_oor ? OOR_DATA : mem_readdata (both masters see same data bus; only valid qualifies).
- Back-to-back reads from either master fully pipelined: one read per cycle, returns in order.
- Counters increment by 1 per accepted command of their master.

## Timing
- Command accept: same cycle as request (zero added latency when uncontended).
- Read latency: data and readdatavalid exactly 1 cycle after acceptance (RAM address registered, q unregistered).
- Contended both-always-requesting: grants strictly alternate 0,1,0,1…
- Reset (sync): all waitrequest = 1, readdatavalid = 0, readdata = 0 (registered-path zero), mem_chipselect = mem_write = 0, counters = 0, err_flags = 0, last_gnt = 1, rd_vld = 0. A read accepted the cycle before reset asserts returns no readdatavalid.
- Write visible to a read accepted the following cycle (RAM write-then-read ordering by port serialisation).

## Structure
- Package nios_systemqsys_mem_arb_pkg: DEPTH, ADDR_W=16, DATA_W=32, BE_W=4, OOR_DATA, master-index typedef (1 bit), err_flags bit positions.
- Sub-module nios_systemqsys_rr_arbiter2: req[1:0], last_gnt register, gnt[1:0] one-hot; top handles muxing, return pipe, counters, flags.

## Test plan
- m0 write addr 0x0010 data 0x12345678 be 4'hF, then m0 read 0x0010 -> waitrequest 0 both cycles; readdatavalid on m0 one cycle later with 0x12345678; grant_cnt0 = 2.
- m0 and m1 both read continuously 8 cycles -> grants 0,1,0,1…; each master gets 4 readdatavalid pulses, never both in one cycle; counts 4/4.
- m1 write be 4'b0010 data 0xAABBCCDD over 0xFFFFFFFF at 0x0100, read back -> 0xFFFFCCFF.
- m0 read 0x9600 (38400) -> mem_chipselect 0, readdata 0xDEADBEEF next cycle, err_flags = 2'b01.
- m1 read+write same cycle -> write applied, no readdatavalid, err_flags[1] = 1.
- Accept m0 read, assert reset next cycle -> no readdatavalid; all outputs at reset values; first post-reset tie goes to m0.

Source files
------------

// File: rtl/nios_systemqsys_mem_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
package nios_systemqsys_mem_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned DEPTH  = 38400;

  localparam logic [DATA_W-1:0] OOR_DATA = 32'hDEAD_BEEF;

  localparam int unsigned ERR_OOR = 0;
  localparam int unsigned ERR_RW  = 1;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_idx_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return 32'(addr) < DEPTH;
  endfunction

endpackage

// File: rtl/nios_systemqsys_rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered last winner.
module nios_systemqsys_rr_arbiter2
  import nios_systemqsys_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  master_idx_t last_gnt_q, last_gnt_d;

  // On a tie the master that did not win last time gets the port.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt_q == M1) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[0])      last_gnt_d = M0;
    else if (gnt[1]) last_gnt_d = M1;
  end

  always_ff @(posedge clk) begin
    if (reset) last_gnt_q <= M1;
    else       last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/nios_systemqsys_onchip_mem_arbiter.sv
// Serialises two Avalon-MM masters onto the single-port on-chip RAM and routes read data back.
module nios_systemqsys_onchip_mem_arbiter
  import nios_systemqsys_mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] m0_address,
  input  logic [3:0]  m0_byteenable,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic [15:0] m1_address,
  input  logic [3:0]  m1_byteenable,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic [15:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  input  logic [31:0] mem_readdata,
  output logic [31:0] grant_cnt0,
  output logic [31:0] grant_cnt1,
  output logic [1:0]  err_flags
);

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        granted;
  logic        sel_read;
  logic        sel_write;
  logic        sel_in_range;
  logic        accept_read;
  logic        ret_live;
  logic [31:0] ret_data;

  logic        rd_vld_q, rd_vld_d;
  master_idx_t rd_owner_q, rd_owner_d;
  logic        rd_oor_q, rd_oor_d;
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [1:0]  err_flags_q, err_flags_d;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  nios_systemqsys_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  always_comb begin
    granted        = |gnt;
    mem_address    = gnt[1] ? m1_address    : m0_address;
    mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
    sel_read       = gnt[1] ? m1_read       : m0_read;
    sel_write      = gnt[1] ? m1_write      : m0_write;
    sel_in_range   = addr_in_range(mem_address);
    mem_chipselect = granted & sel_in_range;
    mem_write      = granted & sel_write;
    mem_clken      = ~reset;
    m0_waitrequest = ~gnt[0];
    m1_waitrequest = ~gnt[1];
    // A simultaneous write wins; the read half is dropped and never returns.
    accept_read    = granted & sel_read & ~sel_write;
  end

  always_comb begin
    rd_vld_d     = accept_read;
    rd_owner_d   = gnt[1] ? M1 : M0;
    rd_oor_d     = ~sel_in_range;
    grant_cnt0_d = grant_cnt0_q + {31'b0, gnt[0]};
    grant_cnt1_d = grant_cnt1_q + {31'b0, gnt[1]};
    err_flags_d  = err_flags_q;
    if (granted && !sel_in_range)    err_flags_d[ERR_OOR] = 1'b1;
    if (granted && sel_read && sel_write) err_flags_d[ERR_RW] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q     <= 1'b0;
      rd_owner_q   <= M0;
      rd_oor_q     <= 1'b0;
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      err_flags_q  <= '0;
    end else begin
      rd_vld_q     <= rd_vld_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      err_flags_q  <= err_flags_d;
    end
  end

  // Return path is held at zero whenever nothing is being returned, including in reset.
  always_comb begin
    ret_live         = rd_vld_q & ~reset;
    ret_data         = rd_oor_q ? OOR_DATA : mem_readdata;
    m0_readdata      = ret_live ? ret_data : '0;
    m1_readdata      = ret_live ? ret_data : '0;
    m0_readdatavalid = ret_live & (rd_owner_q == M0);
    m1_readdatavalid = ret_live & (rd_owner_q == M1);
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_nios_systemqsys_onchip_mem_arbiter.sv
// Directed plus random stimulus checked against a transaction-level model of the arbiter and RAM.
module tb_nios_systemqsys_onchip_mem_arbiter;

  localparam int DEPTH = 38400;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;
  logic [31:0] grant_cnt0, grant_cnt1;
  logic [1:0]  err_flags;

  always #5 clk = ~clk;

  nios_systemqsys_onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_flags(err_flags)
  );

  // Single-port RAM: registered address, unregistered q.
  logic [31:0] ram [0:DEPTH-1];
  logic [15:0] ram_addr_q = '0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [31:0] mdl_mem [int];
  int          mdl_last = 1;
  logic [31:0] mdl_cnt0 = '0, mdl_cnt1 = '0;
  logic [1:0]  mdl_err = '0;
  logic        pend_vld = 1'b0;
  int          pend_owner = 0;
  logic [31:0] pend_data = '0;

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
  endfunction

  // One bus cycle: drive, check mid-cycle against the model, advance the model, cross the edge.
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [15:0] a0,
                      input logic [31:0] d0, input logic [3:0] b0,
                      input logic r1, input logic w1, input logic [15:0] a1,
                      input logic [31:0] d1, input logic [3:0] b1);
    logic r [2]; logic w [2]; logic [15:0] a [2]; logic [31:0] d [2]; logic [3:0] be [2];
    int win;
    logic oor;
    logic [31:0] cur;
    r[0] = r0; w[0] = w0; a[0] = a0; d[0] = d0; be[0] = b0;
    r[1] = r1; w[1] = w1; a[1] = a1; d[1] = d1; be[1] = b1;
    reset = rst;
    m0_read = r0; m0_write = w0; m0_address = a0; m0_writedata = d0; m0_byteenable = b0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_writedata = d1; m1_byteenable = b1;
    #3;
    if (rst) win = -1;
    else if ((r0 | w0) && (r1 | w1)) win = (mdl_last == 1) ? 0 : 1;
    else if (r0 | w0) win = 0;
    else if (r1 | w1) win = 1;
    else win = -1;
    oor = (win >= 0) ? (int'(a[win]) >= DEPTH) : 1'b0;

    chk1("wait0", m0_waitrequest, win != 0);
    chk1("wait1", m1_waitrequest, win != 1);
    chk1("rdv0", m0_readdatavalid, pend_vld && pend_owner == 0 && !rst);
    chk1("rdv1", m1_readdatavalid, pend_vld && pend_owner == 1 && !rst);
    if (pend_vld && !rst) begin
      chk32("rdata0", m0_readdata, pend_data);
      chk32("rdata1", m1_readdata, pend_data);
    end
    if (rst) begin
      chk32("rst_rdata0", m0_readdata, 32'h0);
      chk32("rst_rdata1", m1_readdata, 32'h0);
    end
    chk1("mem_cs", mem_chipselect, win >= 0 && !oor);
    chk1("mem_wr", mem_write, win >= 0 && w[(win >= 0) ? win : 0]);
    chk1("mem_clken", mem_clken, !rst);
    if (win >= 0) chk32("mem_addr", {16'h0, mem_address}, {16'h0, a[win]});
    chk32("cnt0", grant_cnt0, mdl_cnt0);
    chk32("cnt1", grant_cnt1, mdl_cnt1);
    chk32("err", {30'h0, err_flags}, {30'h0, mdl_err});

    if (rst) begin
      mdl_last = 1; pend_vld = 1'b0; mdl_cnt0 = '0; mdl_cnt1 = '0; mdl_err = '0;
    end else begin
      pend_vld = 1'b0;
      if (win >= 0) begin
        mdl_last = win;
        if (win == 0) mdl_cnt0++; else mdl_cnt1++;
        if (oor) mdl_err[0] = 1'b1;
        if (r[win] && w[win]) mdl_err[1] = 1'b1;
        if (w[win] && !oor) begin
          cur = mdl_read(int'(a[win]));
          for (int b = 0; b < 4; b++)
            if (be[win][b]) cur[8*b +: 8] = d[win][8*b +: 8];
          mdl_mem[int'(a[win])] = cur;
        end
        if (r[win] && !w[win]) begin
          pend_vld   = 1'b1;
          pend_owner = win;
          pend_data  = oor ? 32'hDEAD_BEEF : mdl_read(int'(a[win]));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;
    reset = 1'b1;
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 1, 0, 16'h0, 32'h0, 4'h0, 1, 0, 16'h0, 32'h0, 4'h0);

    // Write then read back on m0
    step(0, 0, 1, 16'h0010, 32'h1234_5678, 4'hF, 0, 0, 16'h0, 32'h0, 4'h0);
    step(0, 1, 0, 16'h0010, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
    chk1("wr_rd_rdv0", m0_readdatavalid, 1'b1);
    chk32("wr_rd_data", m0_readdata, 32'h1234_5678);
    chk32("wr_rd_cnt0", grant_cnt0, 32'd2);
    idle();

    // Both masters reading continuously
    for (int i = 0; i < 8; i++)
      step(0, 1, 0, 16'(i), 32'h0, 4'h0, 1, 0, 16'(i + 8), 32'h0, 4'h0);
    idle();
    chk32("contend_cnt0", grant_cnt0, 32'd6);
    chk32("contend_cnt1", grant_cnt1, 32'd4);

    // Partial byte write on m1
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 0, 1, 16'h0100, 32'hFFFF_FFFF, 4'hF);
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 0, 1, 16'h0100, 32'hAABB_CCDD, 4'b0010);
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 1, 0, 16'h0100, 32'h0, 4'h0);
    chk32("be_data", m1_readdata, 32'hFFFF_CCFF);
    idle();

    // Out-of-range read at DEPTH
    step(0, 1, 0, 16'h9600, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
    chk32("oor_data", m0_readdata, 32'hDEAD_BEEF);
    chk32("oor_err", {30'h0, err_flags}, 32'h1);
    // Last valid address stays in range
    step(0, 0, 1, 16'd38399, 32'hCAFE_0001, 4'hF, 0, 0, 16'h0, 32'h0, 4'h0);
    step(0, 1, 0, 16'd38399, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
    chk32("top_addr", m0_readdata, 32'hCAFE_0001);

    // Read and write together on m1
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 1, 1, 16'h0200, 32'h0000_0055, 4'hF);
    chk1("rw_no_rdv", m1_readdatavalid, 1'b0);
    chk32("rw_err", {30'h0, err_flags}, 32'h3);
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 1, 0, 16'h0200, 32'h0, 4'h0);
    chk32("rw_data", m1_readdata, 32'h0000_0055);
    idle();

    // Reset right after an accepted read, then a tie
    step(0, 0, 0, 16'h0, 32'h0, 4'h0, 1, 0, 16'h0010, 32'h0, 4'h0);
    step(0, 1, 0, 16'h0010, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
    step(1, 0, 0, 16'h0, 32'h0, 4'h0, 0, 0, 16'h0, 32'h0, 4'h0);
    chk1("post_rst_rdv0", m0_readdatavalid, 1'b0);
    chk32("post_rst_cnt0", grant_cnt0, 32'h0);
    step(0, 1, 0, 16'h0001, 32'h0, 4'h0, 1, 0, 16'h0002, 32'h0, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic rr0, ww0, rr1, ww1, rst;
      logic [15:0] aa0, aa1;
      rr0 = ($urandom_range(0, 2) != 0);
      ww0 = ($urandom_range(0, 3) == 0);
      rr1 = ($urandom_range(0, 2) != 0);
      ww1 = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0);
      aa0 = ($urandom_range(0, 15) == 0) ? 16'(38398 + $urandom_range(0, 3)) : 16'($urandom_range(0, 15));
      aa1 = ($urandom_range(0, 15) == 0) ? 16'(38398 + $urandom_range(0, 3)) : 16'($urandom_range(0, 15));
      step(rst, rr0, ww0, aa0, $urandom, 4'($urandom), rr1, ww1, aa1, $urandom, 4'($urandom));
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
